tick_irq_ctrl: RTL and testbench
================================

// Module: tick_irq_ctrl
// PURPOSE
//   Downstream of the fast periodic timer. Takes its 1-cycle tick pulse and converts it into a
//   level fabric interrupt (fabint) held until the MSS firmware acknowledges it. Counts ticks
//   that arrive while an interrupt is outstanding and flags overruns. Guarantees a minimum
//   low time between interrupts so the MSS edge detector sees every re-assertion.
// PARAMETERS
//   CNT_W        8   width of pending_cnt (ticks pending since last ack; saturating)
//   HOLDOFF_CYC  4   cycles fabint is held low after an ack (1..2^HOLD_W-1)
//   HOLD_W       3   width of the holdoff counter
// PORTS
//   pclk         in   1       fabric clock; all logic on rising edge
//   reset        in   1       synchronous, active-high reset
//   tick_in      in   1       1-cycle tick pulse from the periodic timer
//   irq_en       in   1       interrupt enable; ticks ignored when low
//   ack          in   1       1-cycle acknowledge strobe from the MSS register write
//   ovr_clr      in   1       1-cycle strobe clearing the sticky overrun flag
//   fabint       out  1       registered level interrupt to the MSS
//   pending_cnt  out  CNT_W   ticks accepted since the last ack
//   overrun      out  1       sticky: a tick arrived while one was already pending
//   ts_last      out  32      cycle timestamp of the last accepted tick (see CONFIGURATION)
// BEHAVIOUR
//   Reset: state=IDLE, fabint=0, pending_cnt=0, overrun=0, ts_last=0, holdoff counter=0.
//     Reset wins over every other input in the same cycle.
//   All outputs are registered. fabint rises on the cycle after the accepted tick (1-cycle latency).
//   Accepted tick = tick_in && irq_en. A tick with irq_en=0 is dropped and not counted.
//   FSM states:
//     IDLE    fabint=0, pending_cnt=0. Accepted tick -> PEND, pending_cnt=1.
//     PEND    fabint=1. Accepted tick: pending_cnt+1, saturating at 2^CNT_W-1; overrun<=1.
//             ack -> HOLDOFF; pending_cnt<=0, or 1 if a tick is accepted in the same cycle.
//               That same-cycle tick does NOT set overrun.
//             irq_en low -> IDLE; pending_cnt<=0; overrun keeps its value.
//     HOLDOFF fabint=0 for exactly HOLDOFF_CYC cycles. Accepted ticks increment pending_cnt,
//             saturating; overrun is not set here. On the last holdoff cycle:
//             pending_cnt>0 -> PEND, else -> IDLE.
//             irq_en low -> IDLE; pending_cnt<=0.
//   ack in IDLE or HOLDOFF: ignored.
//   ovr_clr clears overrun. If ovr_clr and an overrun-setting tick occur in the same cycle,
//     the set wins (overrun=1).
//   pending_cnt is compared and incremented at CNT_W width and never wraps.
//   The holdoff counter loads HOLDOFF_CYC-1 on ack and counts down to 0.
// CONFIGURATION
//   TICK_IRQ_TIMESTAMP_EN defined:
//     Adds a 32-bit free-running cycle counter, cleared by reset, that wraps 0xFFFFFFFF->0.
//     ts_last captures the counter value in the cycle of each accepted tick.
//   TICK_IRQ_TIMESTAMP_EN not defined:
//     No counter is built; ts_last is tied to 0.
//   All other behaviour is identical in both builds.
// TESTING
//   1. reset=1 for 2 cycles while tick_in=1 -> fabint=0, pending_cnt=0, overrun=0 throughout.
//   2. irq_en=1, tick at cycle 10 -> fabint=1 at 11, pending_cnt=1.
//      ack at 15 -> fabint=0 for cycles 16..19 (HOLDOFF_CYC=4), then state IDLE.
//   3. In PEND, 2 more ticks -> pending_cnt=3, overrun=1.
//      ovr_clr -> overrun=0; ovr_clr in the same cycle as a tick -> overrun stays 1.
//   4. ack and tick in the same cycle in PEND -> pending_cnt=1, overrun unchanged,
//      fabint low 4 cycles then high again.
//   5. CNT_W=2: 5 ticks without ack -> pending_cnt saturates at 3.
//      irq_en dropped in PEND -> fabint=0 next cycle, pending_cnt=0.
//   6. With TICK_IRQ_TIMESTAMP_EN: ticks at cycles 100 and 250 after reset -> ts_last=100,
//      then 250. Without the macro: ts_last=0 always.

Source files
------------

// File: rtl/tick_irq_ctrl.sv
// Converts periodic-timer tick pulses into a level fabric interrupt with ack, holdoff and overrun tracking.
// Optional build macro TICK_IRQ_TIMESTAMP_EN adds a free-running cycle counter that timestamps accepted ticks.
module tick_irq_ctrl #(
    parameter int CNT_W       = 8,
    parameter int HOLDOFF_CYC = 4,
    parameter int HOLD_W      = 3
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic             tick_in,
    input  logic             irq_en,
    input  logic             ack,
    input  logic             ovr_clr,
    output logic             fabint,
    output logic [CNT_W-1:0] pending_cnt,
    output logic             overrun,
    output logic [31:0]      ts_last
);

    typedef enum logic [1:0] {IDLE, PEND, HOLDOFF} state_e;

    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_CYC - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cntInc;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              ovr_q, ovr_d, fab_q, fab_d;
    logic              accept, ovrSet;

    assign accept = tick_in & irq_en;
    assign cntInc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            ovr_q   <= 1'b0;
            fab_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            ovr_q   <= ovr_d;
            fab_q   <= fab_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        ovrSet  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = PEND;
                    cnt_d   = CNT_W'(1);
                end
            end
            PEND: begin
                if (!irq_en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (ack) begin
                    // A tick landing with the ack starts the next round, not an overrun.
                    state_d = HOLDOFF;
                    hold_d  = HOLD_LOAD;
                    cnt_d   = CNT_W'(accept);
                end else if (accept) begin
                    cnt_d  = cntInc;
                    ovrSet = 1'b1;
                end
            end
            HOLDOFF: begin
                if (!irq_en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    if (accept) begin
                        cnt_d = cntInc;
                    end
                    if (hold_q == '0) begin
                        state_d = (cnt_d != '0) ? PEND : IDLE;
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Set beats clear so an overrun arriving with the clear strobe is never lost.
    always_comb begin
        fab_d = (state_d == PEND);
        ovr_d = ovrSet | (ovr_q & ~ovr_clr);
    end

    assign fabint      = fab_q;
    assign pending_cnt = cnt_q;
    assign overrun     = ovr_q;

`ifdef TICK_IRQ_TIMESTAMP_EN
    logic [31:0] cyc_q, tsLast_q;

    always_ff @(posedge pclk) begin
        if (reset) begin
            cyc_q    <= '0;
            tsLast_q <= '0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
            if (accept) begin
                tsLast_q <= cyc_q;
            end
        end
    end

    assign ts_last = tsLast_q;
`else
    assign ts_last = '0;
`endif

endmodule

// File: tb/tb_tick_irq_ctrl.sv
// Bench for tick_irq_ctrl: directed literal checks plus randomized traffic against a behavioural model.
// Two instances (CNT_W=8 and CNT_W=2) share the same stimulus so counter saturation is exercised.
module tb_tick_irq_ctrl;

    localparam int HOLDOFF = 4;

    logic        pclk = 1'b0;
    logic        reset, tick_in, irq_en, ack, ovr_clr;
    logic        fabA, ovrA, fabB, ovrB;
    logic [7:0]  cntA;
    logic [1:0]  cntB;
    logic [31:0] tsA, tsB;

    int total = 0;
    int bad   = 0;

    always #5 pclk = ~pclk;

    tick_irq_ctrl #(.CNT_W(8), .HOLDOFF_CYC(HOLDOFF), .HOLD_W(3)) dutA (
        .pclk(pclk), .reset(reset), .tick_in(tick_in), .irq_en(irq_en), .ack(ack),
        .ovr_clr(ovr_clr), .fabint(fabA), .pending_cnt(cntA), .overrun(ovrA), .ts_last(tsA)
    );

    tick_irq_ctrl #(.CNT_W(2), .HOLDOFF_CYC(HOLDOFF), .HOLD_W(3)) dutB (
        .pclk(pclk), .reset(reset), .tick_in(tick_in), .irq_en(irq_en), .ack(ack),
        .ovr_clr(ovr_clr), .fabint(fabB), .pending_cnt(cntB), .overrun(ovrB), .ts_last(tsB)
    );

    // Reference model: "busy" means an interrupt is raised, holdLeft counts remaining quiet cycles.
    int          mBusy[2];
    int          mHoldLeft[2];
    int          mCnt[2];
    bit          mOvr[2];
    int          mMax[2] = '{255, 3};
    logic [31:0] mCyc, mTs;
    bit          started = 1'b0;

    always @(posedge pclk) begin
        bit acc;
        started = 1'b1;
        acc = tick_in && irq_en;
        for (int k = 0; k < 2; k++) begin
            bit setOvr;
            setOvr = 1'b0;
            if (reset) begin
                mBusy[k] = 0; mHoldLeft[k] = 0; mCnt[k] = 0; mOvr[k] = 1'b0;
            end else begin
                if (!irq_en) begin
                    mBusy[k] = 0; mHoldLeft[k] = 0; mCnt[k] = 0;
                end else if (mHoldLeft[k] > 0) begin
                    if (acc) mCnt[k] = (mCnt[k] + 1 > mMax[k]) ? mMax[k] : mCnt[k] + 1;
                    mHoldLeft[k] = mHoldLeft[k] - 1;
                    if (mHoldLeft[k] == 0) mBusy[k] = (mCnt[k] > 0) ? 1 : 0;
                end else if (mBusy[k] != 0) begin
                    if (ack) begin
                        mBusy[k] = 0; mHoldLeft[k] = HOLDOFF; mCnt[k] = acc ? 1 : 0;
                    end else if (acc) begin
                        mCnt[k] = (mCnt[k] + 1 > mMax[k]) ? mMax[k] : mCnt[k] + 1;
                        setOvr = 1'b1;
                    end
                end else if (acc) begin
                    mBusy[k] = 1; mCnt[k] = 1;
                end
                if (setOvr) mOvr[k] = 1'b1;
                else if (ovr_clr) mOvr[k] = 1'b0;
            end
        end
        if (reset) begin
            mCyc = 32'd0; mTs = 32'd0;
        end else begin
            if (acc) mTs = mCyc;
            mCyc = mCyc + 32'd1;
        end
    end

    function automatic logic [31:0] expTs();
`ifdef TICK_IRQ_TIMESTAMP_EN
        return mTs;
`else
        return 32'd0;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model on the falling edge.
    always @(negedge pclk) begin
        if (started) begin
            checkOutput("fabintA",  {31'd0, fabA}, {31'd0, mBusy[0] != 0});
            checkOutput("pendingA", {24'd0, cntA}, 32'(mCnt[0]));
            checkOutput("overrunA", {31'd0, ovrA}, {31'd0, mOvr[0]});
            checkOutput("tsA",      tsA,           expTs());
            checkOutput("fabintB",  {31'd0, fabB}, {31'd0, mBusy[1] != 0});
            checkOutput("pendingB", {30'd0, cntB}, 32'(mCnt[1]));
            checkOutput("overrunB", {31'd0, ovrB}, {31'd0, mOvr[1]});
            checkOutput("tsB",      tsB,           expTs());
        end
    end

    task automatic applyStimulus(input bit r, input bit t, input bit e, input bit a, input bit c);
        reset = r; tick_in = t; irq_en = e; ack = a; ovr_clr = c;
        @(posedge pclk);
        #1;
    endtask

    task automatic pinState(input string tag, input bit fab, input int cnt, input bit ovr);
        checkOutput({tag, "_fab"}, {31'd0, fabA}, {31'd0, fab});
        checkOutput({tag, "_cnt"}, {24'd0, cntA}, 32'(cnt));
        checkOutput({tag, "_ovr"}, {31'd0, ovrA}, {31'd0, ovr});
    endtask

    initial begin
        reset = 1'b1; tick_in = 1'b0; irq_en = 1'b0; ack = 1'b0; ovr_clr = 1'b0;

        applyStimulus(1, 1, 1, 0, 0);
        pinState("reset1", 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 0);
        pinState("reset2", 0, 0, 0);

        for (int i = 0; i < 100; i++) applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        pinState("firstTick", 1, 1, 0);
`ifdef TICK_IRQ_TIMESTAMP_EN
        checkOutput("ts100", tsA, 32'd100);
`else
        checkOutput("tsTied", tsA, 32'd0);
`endif
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 1, 0);
        pinState("holdoff1", 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 0);
        pinState("holdoff4", 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        pinState("backIdle", 0, 0, 0);

        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        pinState("threeTicks", 1, 3, 1);
        applyStimulus(0, 0, 1, 0, 1);
        pinState("ovrClr", 1, 3, 0);
        applyStimulus(0, 1, 1, 0, 1);
        pinState("ovrSetWins", 1, 4, 1);
        checkOutput("satB", {30'd0, cntB}, 32'd3);

        applyStimulus(0, 1, 1, 1, 0);
        pinState("ackTick", 0, 1, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0);
        pinState("ackTickHold", 0, 1, 1);
        applyStimulus(0, 0, 1, 0, 0);
        pinState("reRaise", 1, 1, 1);

        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("satB2", {30'd0, cntB}, 32'd3);
        applyStimulus(0, 0, 0, 0, 0);
        pinState("enDrop", 0, 0, 1);

        for (int i = 0; i < 4000; i++) begin
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 99) < 35,
                          $urandom_range(0, 99) < 93,
                          $urandom_range(0, 99) < 18,
                          $urandom_range(0, 99) < 8);
        end

        @(negedge pclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
